// File: rtl/dma_mem_responder.sv
// dma_mem_responder: arbitrates CPU and DMA access to a single-port data RAM and guards a protected range against DMA
module dma_mem_responder #(
    parameter int          MEM_AW     = 10,
    parameter logic [14:0] MEM_BASE   = 15'h0100,
    parameter logic [3:0]  STARVE_MAX = 4'd8
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [14:0]       dma_addr,
    input  logic [15:0]       dma_din,
    input  logic              dma_en,
    input  logic [1:0]        dma_we,
    input  logic              dma_priority,
    output logic              dma_ready,
    output logic              dma_resp,
    output logic [15:0]       dma_dout,
    input  logic              cpu_mem_cen,
    input  logic [MEM_AW-1:0] cpu_mem_addr,
    input  logic [15:0]       cpu_mem_din,
    input  logic [1:0]        cpu_mem_wen,
    output logic              cpu_mem_wait,
    output logic              mem_cen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_wen,
    input  logic [15:0]       mem_dout,
    input  logic              prot_en,
    input  logic [14:0]       prot_lo,
    input  logic [14:0]       prot_hi,
    output logic              viol_irq,
    output logic [14:0]       viol_addr,
    output logic [7:0]        viol_cnt
);
    localparam logic [15:0] MEM_TOP = {1'b0, MEM_BASE} + (16'd1 << MEM_AW) - 16'd1;

    logic              in_win, in_prot, viol, norm, cpu_req, dma_grant;
    logic [MEM_AW-1:0] dma_off;
    logic [3:0]        starve_q, starve_d;
    logic              dp_valid_q, dp_valid_d, dp_read_q, dp_read_d, dp_viol_q, dp_viol_d;
    logic [14:0]       viol_addr_q, viol_addr_d;
    logic [7:0]        viol_cnt_q, viol_cnt_d;

    always_comb begin
        in_win       = (dma_addr >= MEM_BASE) && ({1'b0, dma_addr} <= MEM_TOP);
        in_prot      = prot_en && (dma_addr >= prot_lo) && (dma_addr <= prot_hi);
        viol         = dma_en && (in_prot || !in_win);
        norm         = dma_en && !viol;
        cpu_req      = !cpu_mem_cen;
        // a starved request wins once the stall budget is used up
        dma_grant    = norm && (!cpu_req || dma_priority || starve_q == STARVE_MAX - 4'd1);
        dma_ready    = viol || dma_grant;
        cpu_mem_wait = cpu_req && dma_grant;
        dma_off      = dma_addr[MEM_AW-1:0] - MEM_BASE[MEM_AW-1:0];
        mem_cen      = dma_grant ? 1'b0 : cpu_mem_cen;
        mem_addr     = dma_grant ? dma_off : cpu_mem_addr;
        mem_din      = dma_grant ? dma_din : cpu_mem_din;
        mem_wen      = dma_grant ? ~dma_we : (cpu_req ? cpu_mem_wen : 2'b11);
        starve_d     = (norm && !dma_grant) ? starve_q + 4'd1 : 4'd0;
        dp_valid_d   = dma_ready;
        dp_read_d    = dma_we == 2'b00;
        dp_viol_d    = viol;
        viol_addr_d  = viol ? dma_addr : viol_addr_q;
        viol_cnt_d   = (viol && viol_cnt_q != 8'hFF) ? viol_cnt_q + 8'd1 : viol_cnt_q;
        dma_resp     = dp_valid_q && dp_viol_q;
        viol_irq     = dp_valid_q && dp_viol_q;
        dma_dout     = (dp_valid_q && dp_read_q && !dp_viol_q) ? mem_dout : 16'h0000;
        viol_addr    = viol_addr_q;
        viol_cnt     = viol_cnt_q;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            starve_q    <= 4'd0;
            dp_valid_q  <= 1'b0;
            dp_read_q   <= 1'b0;
            dp_viol_q   <= 1'b0;
            viol_addr_q <= 15'd0;
            viol_cnt_q  <= 8'd0;
        end else begin
            starve_q    <= starve_d;
            dp_valid_q  <= dp_valid_d;
            dp_read_q   <= dp_read_d;
            dp_viol_q   <= dp_viol_d;
            viol_addr_q <= viol_addr_d;
            viol_cnt_q  <= viol_cnt_d;
        end
    end
endmodule

// File: tb/tb_dma_mem_responder.sv
// tb_dma_mem_responder: table vectors, corner sequences and random traffic against a behavioural model
module tb_dma_mem_responder;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [14:0] BASE  = 15'h0100;
    localparam int          SMAX  = 8;

    logic          mclk, puc_rst;
    logic [14:0]   dma_addr;
    logic [15:0]   dma_din;
    logic          dma_en;
    logic [1:0]    dma_we;
    logic          dma_priority, dma_ready, dma_resp;
    logic [15:0]   dma_dout;
    logic          cpu_mem_cen;
    logic [AW-1:0] cpu_mem_addr;
    logic [15:0]   cpu_mem_din;
    logic [1:0]    cpu_mem_wen;
    logic          cpu_mem_wait, mem_cen;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_wen;
    logic [15:0]   mem_dout;
    logic          prot_en;
    logic [14:0]   prot_lo, prot_hi;
    logic          viol_irq;
    logic [14:0]   viol_addr;
    logic [7:0]    viol_cnt;

    dma_mem_responder #(.MEM_AW(AW), .MEM_BASE(BASE), .STARVE_MAX(4'd8)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en),
        .dma_we(dma_we), .dma_priority(dma_priority), .dma_ready(dma_ready), .dma_resp(dma_resp),
        .dma_dout(dma_dout), .cpu_mem_cen(cpu_mem_cen), .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_din(cpu_mem_din), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_wait(cpu_mem_wait),
        .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_wen(mem_wen),
        .mem_dout(mem_dout), .prot_en(prot_en), .prot_lo(prot_lo), .prot_hi(prot_hi),
        .viol_irq(viol_irq), .viol_addr(viol_addr), .viol_cnt(viol_cnt)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // synchronous single-port RAM, read-first, byte write enables active-low
    logic [15:0] ram [0:DEPTH-1];
    always @(posedge mclk) begin
        if (!mem_cen) begin
            if (!mem_wen[0]) ram[mem_addr][7:0] <= mem_din[7:0];
            if (!mem_wen[1]) ram[mem_addr][15:8] <= mem_din[15:8];
            mem_dout <= ram[mem_addr];
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [15:0] mm [0:DEPTH-1];
    int          m_starve, m_cnt;
    bit          p_valid, p_read, p_viol;
    logic [15:0] p_data;
    logic [14:0] m_vaddr;

    task automatic model_reset();
        m_starve = 0; m_cnt = 0; m_vaddr = '0;
        p_valid = 0; p_read = 0; p_viol = 0; p_data = '0;
    endtask

    task automatic mwrite(input int idx, input logic [1:0] en, input logic [15:0] d);
        if (en[0]) mm[idx][7:0] = d[7:0];
        if (en[1]) mm[idx][15:8] = d[15:8];
    endtask

    // check the current cycle against the model, advance the model, move to the next negedge
    task automatic tick();
        bit v, nrm, cpu, go;
        int a, off;
        logic [1:0] w;
        logic [15:0] ed;
        a   = int'(dma_addr);
        v   = dma_en && ((prot_en && a >= int'(prot_lo) && a <= int'(prot_hi)) ||
                         a < int'(BASE) || a >= int'(BASE) + DEPTH);
        nrm = dma_en && !v;
        cpu = !cpu_mem_cen;
        go  = nrm && (!cpu || dma_priority || m_starve == SMAX - 1);
        off = a - int'(BASE);
        chk("dma_ready", dma_ready, v || go);
        chk("cpu_mem_wait", cpu_mem_wait, cpu && go);
        if (go) begin
            w = ~dma_we;
            chk("mem_cen_dma", mem_cen, 0);
            chk("mem_addr_dma", mem_addr, off);
            chk("mem_din_dma", mem_din, dma_din);
            chk("mem_wen_dma", mem_wen, w);
        end else if (cpu) begin
            chk("mem_cen_cpu", mem_cen, 0);
            chk("mem_addr_cpu", mem_addr, cpu_mem_addr);
            chk("mem_din_cpu", mem_din, cpu_mem_din);
            chk("mem_wen_cpu", mem_wen, cpu_mem_wen);
        end else begin
            chk("mem_cen_idle", mem_cen, 1);
            chk("mem_wen_idle", mem_wen, 2'b11);
        end
        ed = (p_valid && p_read && !p_viol) ? p_data : 16'h0000;
        chk("dma_resp", dma_resp, p_valid && p_viol);
        chk("viol_irq", viol_irq, p_valid && p_viol);
        chk("dma_dout", dma_dout, ed);
        chk("viol_cnt", viol_cnt, m_cnt);
        chk("viol_addr", viol_addr, m_vaddr);
        p_valid = v || go;
        p_viol  = v;
        p_read  = dma_we == 2'b00;
        p_data  = go ? mm[off] : 16'h0000;
        if (go) mwrite(off, dma_we, dma_din);
        else if (cpu) begin
            w = ~cpu_mem_wen;
            mwrite(int'(cpu_mem_addr), w, cpu_mem_din);
        end
        if (v) begin
            m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_vaddr = dma_addr;
        end
        m_starve = (nrm && !go) ? m_starve + 1 : 0;
        @(negedge mclk);
    endtask

    task automatic idle_in();
        dma_en = 0; dma_we = 2'b00; dma_priority = 0; cpu_mem_cen = 1; cpu_mem_wen = 2'b11;
    endtask

    task automatic dma_set(input logic [14:0] a, input logic [1:0] we, input logic [15:0] d);
        dma_en = 1; dma_addr = a; dma_we = we; dma_din = d;
    endtask

    typedef struct {
        string       name;
        logic        en;
        logic [14:0] addr;
        logic [1:0]  we;
        logic        pri;
        logic        ccen;
        logic        pe;
        logic        r;
        logic        w;
        logic        mc;
    } vec_t;

    vec_t tbl [14];
    int   stalls, pulses, o;
    bit   got;

    initial begin
        tbl[0]  = '{"idle",        1'b0, BASE,          2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{"uncont_rd",   1'b1, BASE+15'd5,    2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{"cpu_only",    1'b0, BASE,          2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{"dma_pri",     1'b1, BASE+15'd6,    2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{"cpu_wins",    1'b1, BASE+15'd7,    2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{"prot_cpu",    1'b1, BASE+15'd20,   2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{"prot_hit",    1'b1, BASE+15'd20,   2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{"prot_lo",     1'b1, BASE+15'd16,   2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{"prot_hi",     1'b1, BASE+15'd31,   2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{"above_prot",  1'b1, BASE+15'd32,   2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{"below_base",  1'b1, BASE-15'd1,    2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{"top_window",  1'b1, BASE+15'd1023, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{"past_window", 1'b1, BASE+15'd1024, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{"prot_off",    1'b1, BASE+15'd20,   2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0000;
        idle_in();
        dma_addr = BASE; dma_din = 0; cpu_mem_addr = 0; cpu_mem_din = 0;
        prot_en = 0; prot_lo = BASE + 15'd16; prot_hi = BASE + 15'd31;
        puc_rst = 1;
        model_reset();
        repeat (2) @(negedge mclk);
        #1;
        chk("rst_dma_resp", dma_resp, 0);
        chk("rst_dma_dout", dma_dout, 0);
        chk("rst_viol_irq", viol_irq, 0);
        chk("rst_viol_cnt", viol_cnt, 0);
        chk("rst_viol_addr", viol_addr, 0);
        chk("rst_mem_cen", mem_cen, 1);
        chk("rst_mem_wen", mem_wen, 2'b11);
        @(negedge mclk);
        puc_rst = 0;

        // clear the RAM words used below
        for (int i = 0; i < 37; i++) begin
            dma_set(BASE + 15'((i <= 32) ? i : 1020 + i - 33), 2'b11, 16'h0000);
            #1; tick();
        end
        idle_in(); #1; tick();

        foreach (tbl[i]) begin
            dma_en = tbl[i].en; dma_addr = tbl[i].addr; dma_we = tbl[i].we; dma_din = 16'hA5A5;
            dma_priority = tbl[i].pri; cpu_mem_cen = tbl[i].ccen; prot_en = tbl[i].pe;
            cpu_mem_addr = 9; cpu_mem_wen = 2'b11; cpu_mem_din = 16'h3C3C;
            #1;
            chk({tbl[i].name, "_ready"}, dma_ready, tbl[i].r);
            chk({tbl[i].name, "_wait"}, cpu_mem_wait, tbl[i].w);
            chk({tbl[i].name, "_mem_cen"}, mem_cen, tbl[i].mc);
            tick();
            idle_in(); prot_en = 0; #1; tick();
        end

        // uncontended read
        dma_set(BASE + 15'd5, 2'b11, 16'hBEEF); #1; tick();
        dma_set(BASE + 15'd5, 2'b00, 16'h0000); #1; tick();
        idle_in(); #1;
        chk("rd_beef_dout", dma_dout, 16'hBEEF);
        chk("rd_beef_resp", dma_resp, 0);
        tick();

        // high-byte write
        dma_set(BASE + 15'd3, 2'b11, 16'h5566); #1; tick();
        dma_set(BASE + 15'd3, 2'b10, 16'h12AB); #1; tick();
        dma_set(BASE + 15'd3, 2'b00, 16'h0000); #1; tick();
        idle_in(); #1;
        chk("byte_wr", dma_dout, 16'h1266);
        tick();

        // starvation under continuous CPU traffic
        dma_set(BASE + 15'd10, 2'b00, 16'h0000);
        cpu_mem_cen = 0; cpu_mem_addr = 11; cpu_mem_wen = 2'b11;
        stalls = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (dma_ready) begin
                got = 1;
                chk("starve_wait", cpu_mem_wait, 1);
            end else begin
                stalls++;
                chk("stall_wait", cpu_mem_wait, 0);
            end
            tick();
        end
        chk("starve_grant", got, 1);
        chk("stall_cycles", stalls, SMAX - 1);
        idle_in(); #1; tick();
        dma_set(BASE + 15'd10, 2'b00, 16'h0000); dma_priority = 1; cpu_mem_cen = 0;
        #1;
        chk("pri_ready", dma_ready, 1);
        chk("pri_wait", cpu_mem_wait, 1);
        tick();
        idle_in(); #1; tick();

        // protected write is refused, neighbour just above is accepted
        prot_en = 1; prot_lo = BASE + 15'd16; prot_hi = BASE + 15'd31;
        dma_set(BASE + 15'd20, 2'b11, 16'hFFFF);
        #1;
        chk("prot_mem_cen", mem_cen, 1);
        chk("prot_ready", dma_ready, 1);
        tick();
        dma_set(BASE + 15'd32, 2'b11, 16'h1234);
        #1;
        chk("prot_resp", dma_resp, 1);
        chk("prot_irq", viol_irq, 1);
        chk("prot_vaddr", viol_addr, BASE + 15'd20);
        chk("above_mem_cen", mem_cen, 0);
        chk("above_ready", dma_ready, 1);
        tick();
        idle_in(); #1;
        chk("above_resp", dma_resp, 0);
        chk("above_irq", viol_irq, 0);
        tick();
        prot_en = 0;
        dma_set(BASE + 15'd20, 2'b00, 16'h0000); #1; tick();
        idle_in(); #1;
        chk("ram_unchanged", dma_dout, 16'h0000);
        tick();

        // out-of-window reads saturate the counter
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            dma_set(15'h0000, 2'b00, 16'h0000);
            #1;
            if (dma_resp) pulses++;
            tick();
        end
        idle_in(); #1;
        if (dma_resp) pulses++;
        tick();
        chk("oow_pulses", pulses, 300);
        #1;
        chk("oow_sat", viol_cnt, 8'hFF);
        tick();

        // reset during a violation data phase
        dma_set(15'h0000, 2'b00, 16'h0000); #1; tick();
        idle_in();
        puc_rst = 1;
        model_reset();
        #1;
        chk("rstdp_resp", dma_resp, 0);
        chk("rstdp_irq", viol_irq, 0);
        chk("rstdp_cnt", viol_cnt, 0);
        @(negedge mclk);
        puc_rst = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_resp", dma_resp, 0);
            chk("post_rst_irq", viol_irq, 0);
            tick();
        end

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            if (i % 64 == 0) begin
                prot_en = 1'($urandom_range(0, 1));
                prot_lo = BASE + 15'($urandom_range(0, 20));
                prot_hi = prot_lo + 15'($urandom_range(0, 12));
            end
            case ($urandom_range(0, 9))
                7:       dma_addr = BASE - 15'd1 - 15'($urandom_range(0, 3));
                8:       dma_addr = BASE + 15'd1024 + 15'($urandom_range(0, 3));
                9:       dma_addr = 15'h7000 + 15'($urandom_range(0, 255));
                default: begin
                    o = $urandom_range(0, 36);
                    dma_addr = BASE + 15'((o <= 32) ? o : 1020 + o - 33);
                end
            endcase
            dma_en       = $urandom_range(0, 3) != 0;
            dma_we       = 2'($urandom_range(0, 3));
            dma_din      = 16'($urandom);
            dma_priority = $urandom_range(0, 3) == 0;
            cpu_mem_cen  = 1'($urandom_range(0, 1));
            cpu_mem_addr = AW'($urandom_range(0, 32));
            cpu_mem_wen  = 2'($urandom_range(0, 3));
            cpu_mem_din  = 16'($urandom);
            #1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
